// File: rtl/tmon_cmd_master_if.sv
// Requester, monitor command bus, monitor response and status signals of tmon_cmd_master.
// master = command-master view, slave = requester/monitor environment view.
interface tmon_cmd_master_if #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [CHW-1:0] req_ch;
    logic [DW-1:0]  req_data;

    logic           m_valid;
    logic           m_ready;
    logic [2:0]     m_op;
    logic [CHW-1:0] m_ch;
    logic [DW-1:0]  m_opnd;

    logic           s_rsp_valid;
    logic [DW-1:0]  s_rsp_data;

    logic           done;
    logic           rsp_valid;
    logic [CHW-1:0] rsp_ch;
    logic [DW-1:0]  rsp_data;
    logic           err;
    logic [1:0]     err_code;
    logic [CW-1:0]  fifo_count;

    modport master (
        input  req_valid, req_op, req_ch, req_data, m_ready, s_rsp_valid, s_rsp_data,
        output req_ready, m_valid, m_op, m_ch, m_opnd,
               done, rsp_valid, rsp_ch, rsp_data, err, err_code, fifo_count
    );

    modport slave (
        output req_valid, req_op, req_ch, req_data, m_ready, s_rsp_valid, s_rsp_data,
        input  req_ready, m_valid, m_op, m_ch, m_opnd,
               done, rsp_valid, rsp_ch, rsp_data, err, err_code, fifo_count
    );
endinterface

// File: rtl/tmon_cmd_master.sv
// Queues monitor opcodes in a DEPTH-entry FIFO and issues them one at a time over a
// valid/ready bus, waiting (with timeout) for READ_TEMP responses; req_ready drops when full.
module tmon_cmd_master #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    tmon_cmd_master_if.master bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int TW  = $clog2(TIMEOUT);

    localparam logic [2:0]    OP_NOOP  = 3'd0;
    localparam logic [2:0]    OP_RESET = 3'd1;
    localparam logic [2:0]    OP_READ  = 3'd5;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [2:0]     op;
        logic [CHW-1:0] ch;
        logic [DW-1:0]  dat;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    cmd_t           r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count, w_count_nxt;
    logic           r_req_rdy;
    logic [TW-1:0]  r_tmo_cnt;

    logic           r_m_valid;
    logic [2:0]     r_m_op;
    logic [CHW-1:0] r_m_ch;
    logic [DW-1:0]  r_m_opnd;
    logic           r_done, r_rsp_valid, r_err;
    logic [CHW-1:0] r_rsp_ch;
    logic [DW-1:0]  r_rsp_data;
    logic [1:0]     r_err_code;

    logic w_accept, w_illegal, w_push, w_pop, w_hs, w_flush, w_rsp, w_tmo;

    assign w_accept  = bus.req_valid && r_req_rdy;
    assign w_illegal = w_accept && ((bus.req_op > 3'd5) || (32'(bus.req_ch) >= NCH));
    assign w_push    = w_accept && !w_illegal && (bus.req_op != OP_NOOP);
    assign w_flush   = w_hs && (r_m_op == OP_RESET);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hs        = 1'b0;
        w_rsp       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.m_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = (r_m_op == OP_READ) ? S_WAIT_RSP : S_DONE;
                end
            end
            S_WAIT_RSP: begin
                // A response in the final timeout cycle takes priority over the timeout.
                if (bus.s_rsp_valid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = w_push ? CW'(1) : '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{op: bus.req_op, ch: bus.req_ch, dat: bus.req_data};
    end

    // A RESET flush empties the queue by snapping rd to the pre-push wr pointer,
    // which keeps any request accepted in the same cycle as the sole entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_req_rdy <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_flush)    r_rd_ptr <= r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_nxt;
            r_req_rdy <= (w_count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid   <= 1'b0;
            r_m_op      <= '0;
            r_m_ch      <= '0;
            r_m_opnd    <= '0;
            r_tmo_cnt   <= '0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_ch    <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_done      <= (r_state == S_DONE);
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            if (w_pop) begin
                r_m_valid <= 1'b1;
                r_m_op    <= r_mem[r_rd_ptr].op;
                r_m_ch    <= r_mem[r_rd_ptr].ch;
                r_m_opnd  <= r_mem[r_rd_ptr].dat;
            end
            if (w_hs) begin
                r_m_valid <= 1'b0;
                r_tmo_cnt <= '0;
            end
            if (r_state == S_WAIT_RSP && !w_rsp && r_tmo_cnt != TMO_LAST)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_ch    <= r_m_ch;
                r_rsp_data  <= bus.s_rsp_data;
            end
            if (w_tmo) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd2;
            end else if (w_illegal) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
            end
        end
    end

    assign bus.req_ready  = r_req_rdy;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_op       = r_m_op;
    assign bus.m_ch       = r_m_ch;
    assign bus.m_opnd     = r_m_opnd;
    assign bus.done       = r_done;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_ch     = r_rsp_ch;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_tmon_cmd_master.sv
// Directed bench for tmon_cmd_master; NCH=3 so an out-of-range channel (3) fits in req_ch.
module tb_tmon_cmd_master;
    localparam int NCH = 3, DW = 8, DEPTH = 4, TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tmon_cmd_master_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

    tmon_cmd_master #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [1:0] ch, input logic [7:0] dat);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_ch    = ch;
        bus.req_data  = dat;
    endtask

    task automatic wait_mvalid(input string tag);
        int n = 0;
        while (bus.m_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.m_valid), 1);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_op = 0; bus.req_ch = 0; bus.req_data = 0;
        bus.m_ready = 0; bus.s_rsp_valid = 0; bus.s_rsp_data = 0;
        tick(); tick();
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        reset = 1'b0;
        tick();
        check("idle_req_ready", 32'(bus.req_ready), 1);

        // SET_FRQ ch2 0x3C, monitor always ready
        bus.m_ready = 1;
        push(3'd2, 2'd2, 8'h3C);
        tick();
        bus.req_valid = 0;
        check("frq_count", 32'(bus.fifo_count), 1);
        check("frq_mvalid_lat", 32'(bus.m_valid), 0);
        tick();
        check("frq_mvalid", 32'(bus.m_valid), 1);
        check("frq_op", 32'(bus.m_op), 2);
        check("frq_ch", 32'(bus.m_ch), 2);
        check("frq_opnd", 32'(bus.m_opnd), 32'h3C);
        tick();
        check("frq_mvalid_drop", 32'(bus.m_valid), 0);
        check("frq_done_early", 32'(bus.done), 0);
        tick();
        check("frq_done", 32'(bus.done), 1);
        tick();
        check("frq_done_pulse", 32'(bus.done), 0);

        // Fill with SET_HIGH_TEMP while the monitor stalls
        bus.m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            push(3'd3, 2'd0, 8'(8'h10 + i));
            tick();
        end
        check("full_count", 32'(bus.fifo_count), 4);
        check("full_req_ready", 32'(bus.req_ready), 0);
        check("full_head", 32'(bus.m_opnd), 32'h10);
        push(3'd3, 2'd0, 8'h15);
        tick();
        bus.req_valid = 0;
        check("full_no_accept", 32'(bus.fifo_count), 4);
        bus.m_ready = 1;
        for (int k = 0; k < 5; k++) begin
            wait_mvalid("fill_wait");
            check("fill_order", 32'(bus.m_opnd), 32'(8'h10 + k));
            check("fill_op", 32'(bus.m_op), 3);
            tick();
        end
        tick(); tick(); tick();

        // Wrap the pointers with four more entries
        bus.m_ready = 0;
        for (int i = 0; i < 4; i++) begin
            push(3'd4, 2'd1, 8'(8'h20 + i));
            tick();
        end
        bus.req_valid = 0;
        check("wrap_count", 32'(bus.fifo_count), 3);
        bus.m_ready = 1;
        for (int k = 0; k < 4; k++) begin
            wait_mvalid("wrap_wait");
            check("wrap_order", 32'(bus.m_opnd), 32'(8'h20 + k));
            tick();
        end
        tick(); tick(); tick();

        // Stray response outside WAIT_RSP
        bus.s_rsp_valid = 1; bus.s_rsp_data = 8'hAA;
        tick();
        bus.s_rsp_valid = 0;
        check("stray_rsp", 32'(bus.rsp_valid), 0);

        // READ_TEMP ch1, response 3 cycles after the command handshake
        push(3'd5, 2'd1, 8'h00);
        tick();
        bus.req_valid = 0;
        tick();
        check("rd_op", 32'(bus.m_op), 5);
        tick();
        tick(); tick();
        bus.s_rsp_valid = 1; bus.s_rsp_data = 8'h55;
        tick();
        bus.s_rsp_valid = 0;
        check("rd_rsp_valid", 32'(bus.rsp_valid), 1);
        check("rd_rsp_ch", 32'(bus.rsp_ch), 1);
        check("rd_rsp_data", 32'(bus.rsp_data), 32'h55);
        check("rd_done_early", 32'(bus.done), 0);
        tick();
        check("rd_done", 32'(bus.done), 1);
        check("rd_rsp_pulse", 32'(bus.rsp_valid), 0);
        tick();

        // READ_TEMP ch2 with no response; illegal request lands on the timeout cycle
        push(3'd5, 2'd2, 8'h00);
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("tmo_not_yet", 32'(bus.err), 0);
        push(3'd6, 2'd0, 8'h00);
        tick();
        bus.req_valid = 0;
        check("tmo_err", 32'(bus.err), 1);
        check("tmo_code", 32'(bus.err_code), 2);
        check("tmo_no_rsp", 32'(bus.rsp_valid), 0);
        check("tmo_rsp_hold", 32'(bus.rsp_data), 32'h55);
        check("tmo_count", 32'(bus.fifo_count), 0);
        tick();
        check("tmo_err_pulse", 32'(bus.err), 0);
        check("tmo_code_hold", 32'(bus.err_code), 2);
        check("tmo_done", 32'(bus.done), 1);
        tick();

        // READ_TEMP ch0 answered exactly in the timeout cycle
        push(3'd5, 2'd0, 8'h00);
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        bus.s_rsp_valid = 1; bus.s_rsp_data = 8'h66;
        tick();
        bus.s_rsp_valid = 0;
        check("edge_rsp_valid", 32'(bus.rsp_valid), 1);
        check("edge_rsp_data", 32'(bus.rsp_data), 32'h66);
        check("edge_no_err", 32'(bus.err), 0);
        tick(); tick();

        // Illegal opcode, out-of-range channel, NOOP
        push(3'd7, 2'd0, 8'h01);
        tick();
        bus.req_valid = 0;
        check("ill_op_err", 32'(bus.err), 1);
        check("ill_op_code", 32'(bus.err_code), 1);
        check("ill_op_count", 32'(bus.fifo_count), 0);
        tick();
        check("ill_op_pulse", 32'(bus.err), 0);
        push(3'd2, 2'd3, 8'h02);
        tick();
        bus.req_valid = 0;
        check("ill_ch_err", 32'(bus.err), 1);
        check("ill_ch_count", 32'(bus.fifo_count), 0);
        push(3'd0, 2'd0, 8'h03);
        tick();
        bus.req_valid = 0;
        check("noop_count", 32'(bus.fifo_count), 0);
        check("noop_err", 32'(bus.err), 0);
        tick();
        check("noop_mvalid", 32'(bus.m_valid), 0);
        check("noop_done", 32'(bus.done), 0);

        // RESET flush with a push on the RESET handshake cycle
        bus.m_ready = 0;
        push(3'd2, 2'd0, 8'h01); tick();
        push(3'd1, 2'd0, 8'h02); tick();
        push(3'd2, 2'd0, 8'h03); tick();
        push(3'd2, 2'd0, 8'h04); tick();
        bus.req_valid = 0;
        check("flush_pre_count", 32'(bus.fifo_count), 3);
        bus.m_ready = 1;
        tick();
        for (int n = 0; n < 10 && !(bus.m_valid === 1'b1 && bus.m_op === 3'd1); n++) tick();
        check("flush_reset_issued", 32'(bus.m_op), 1);
        check("flush_mid_count", 32'(bus.fifo_count), 2);
        push(3'd2, 2'd1, 8'h77);
        tick();
        bus.req_valid = 0;
        bus.m_ready = 0;
        check("flush_count", 32'(bus.fifo_count), 1);
        wait_mvalid("flush_wait");
        check("flush_next_opnd", 32'(bus.m_opnd), 32'h77);
        check("flush_next_ch", 32'(bus.m_ch), 1);

        // Asynchronous reset while stalled in ISSUE
        push(3'd3, 2'd0, 8'h88);
        tick();
        bus.req_valid = 0;
        check("pre_rst_count", 32'(bus.fifo_count), 1);
        reset = 1'b1;
        #1;
        check("arst_m_valid", 32'(bus.m_valid), 0);
        check("arst_m_opnd", 32'(bus.m_opnd), 0);
        check("arst_count", 32'(bus.fifo_count), 0);
        check("arst_err_code", 32'(bus.err_code), 0);
        check("arst_rsp_data", 32'(bus.rsp_data), 0);
        tick();
        reset = 1'b0;
        bus.m_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_done", 32'(bus.done), 0);
            check("post_rst_mvalid", 32'(bus.m_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
